mole_controller: RTL

//  Game core downstream of clk_divider. Consumes the lfsr_clk and clk_1Hz one-cycle strobes.

---
 rtl/mole_controller.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mole_controller.sv
// Whack-a-mole game core: spawns and ages moles from a 16-bit LFSR, scores hits, counts misses, runs the timer.
// Latency: every strobe (lfsr_tick, sec_tick, start, whack) is reflected on the registered outputs one cycle later.
// Backpressure: none; every strobe is consumed in the cycle it arrives, and strobes that have no effect in the current state are dropped.
module mole_controller #(
   parameter int          MOLE_LIFE  = 3,
   parameter int          GAME_SECS  = 60,
   parameter int          MAX_MISSES = 10,
   parameter int          LVL2_SCORE = 10,
   parameter int          LVL3_SCORE = 25,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       lfsr_tick,
   input  logic       sec_tick,
   input  logic       start,
   input  logic [8:0] whack,
   output logic [8:0] moles,
   output logic [7:0] score,
   output logic [7:0] misses,
   output logic [7:0] time_left,
   output logic [1:0] lvl,
   output logic       playing,
   output logic       game_over
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      OVER = 2'd2
   } state_t;

   localparam logic [1:0] LIFE_INIT = 2'(MOLE_LIFE);
   localparam logic [7:0] SECS_INIT = 8'(GAME_SECS);
   localparam logic [7:0] MISS_MAX  = 8'(MAX_MISSES);
   localparam logic [7:0] LVL2_THR  = 8'(LVL2_SCORE);
   localparam logic [7:0] LVL3_THR  = 8'(LVL3_SCORE);

   state_t          state, state_n;
   logic [15:0]     lfsr;
   logic [8:0][1:0] life, life_n;
   logic [8:0]      moles_n;
   logic [7:0]      score_n, misses_n, time_n;
   logic [1:0]      lvl_n;
   logic [3:0]      hole;
   logic [8:0]      hits, expired;
   logic [8:0]      score_sum, miss_sum;

   function automatic logic [3:0] pop9(input logic [8:0] v);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < 9; i++) c = c + {3'b000, v[i]};
      return c;
   endfunction

   // Fold the low LFSR nibble into the 0..8 hole range (values 9..15 wrap once).
   assign hole = (lfsr[3:0] >= 4'd9) ? (lfsr[3:0] - 4'd9) : lfsr[3:0];

   // LFSR steps on every lfsr_tick regardless of game state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr <= LFSR_SEED;
      else if (lfsr_tick) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Next state and next values of the whole game datapath.
   always_comb begin
      state_n   = state;
      moles_n   = moles;
      life_n    = life;
      score_n   = score;
      misses_n  = misses;
      time_n    = time_left;
      lvl_n     = lvl;
      hits      = '0;
      expired   = '0;
      score_sum = '0;
      miss_sum  = '0;
      case (state)
         IDLE, OVER: begin
            if (start) begin
               state_n  = PLAY;
               moles_n  = '0;
               life_n   = '0;
               score_n  = '0;
               misses_n = '0;
               time_n   = SECS_INIT;
               lvl_n    = 2'd1;
            end
         end
         PLAY: begin
            // A whack on an up mole always wins, with or without a tick.
            hits = moles & whack;
            if (lfsr_tick) begin
               for (int i = 0; i < 9; i++) begin
                  if (moles[i] && !whack[i]) begin
                     if (life[i] == 2'd1) expired[i] = 1'b1;
                     else                 life_n[i] = life[i] - 2'd1;
                  end
               end
            end
            moles_n = moles & ~hits & ~expired;
            for (int i = 0; i < 9; i++) begin
               if (hits[i] || expired[i]) life_n[i] = 2'd0;
            end
            // Spawn only into a hole that was empty before this cycle; otherwise the tick is lost.
            if (lfsr_tick && !moles[hole]) begin
               moles_n[hole] = 1'b1;
               life_n[hole]  = LIFE_INIT;
            end
            score_sum = {1'b0, score} + {5'b00000, pop9(hits)};
            score_n   = score_sum[8] ? 8'hFF : score_sum[7:0];
            miss_sum  = {1'b0, misses} + {5'b00000, pop9(expired)};
            misses_n  = (miss_sum >= {1'b0, MISS_MAX}) ? MISS_MAX : miss_sum[7:0];
            if (sec_tick && time_left != 8'd0) time_n = time_left - 8'd1;
            if (score_n >= LVL3_THR)      lvl_n = 2'd3;
            else if (score_n >= LVL2_THR) lvl_n = 2'd2;
            else                          lvl_n = 2'd1;
            if (time_n == 8'd0 || misses_n >= MISS_MAX) begin
               state_n = OVER;
               moles_n = '0;
               life_n  = '0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Registered outputs and per-hole life counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         moles     <= '0;
         life      <= '0;
         score     <= '0;
         misses    <= '0;
         time_left <= '0;
         lvl       <= 2'd1;
         playing   <= 1'b0;
         game_over <= 1'b0;
      end else begin
         moles     <= moles_n;
         life      <= life_n;
         score     <= score_n;
         misses    <= misses_n;
         time_left <= time_n;
         lvl       <= lvl_n;
         playing   <= (state_n == PLAY);
         game_over <= (state_n == OVER);
      end
   end

endmodule
